// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Memory instance (address bus, tri-state data bus,
// write strobe) between two bus masters. One transaction runs at a time
// through an IDLE -> BUSY -> DONE sequence; the winner gets registered read
// data and a one-cycle ack.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// without it port 0 always wins a tie.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              busy,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              write_mode
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    lat_cnt;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                drive_en;
  logic                pick1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = port 1 won the last grant, so port 0 takes the next tie
  logic                last_win1;

  // Round-robin winner select: a tie goes to the port that did not win last
  always_comb begin
    pick1 = req1 & (~req0 | ~last_win1);
  end
`else
  // Fixed-priority winner select: port 1 only when port 0 is not requesting
  always_comb begin
    pick1 = req1 & ~req0;
  end
`endif

  // Memory data bus is driven only while a write is in BUSY
  assign data_bus = drive_en ? wdata_q : {DATA_W{1'bz}};

  // Transaction FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      drive_en    <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      grant       <= 2'b00;
      address_bus <= '0;
      write_mode  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_win1   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (req0 || req1) begin
            grant       <= pick1 ? 2'b10 : 2'b01;
            we_q        <= pick1 ? we1 : we0;
            wdata_q     <= pick1 ? wdata1 : wdata0;
            address_bus <= pick1 ? addr1 : addr0;
            write_mode  <= pick1 ? we1 : we0;
            drive_en    <= pick1 ? we1 : we0;
            lat_cnt     <= (pick1 ? we1 : we0) ? '0 : CNT_W'(READ_LAT - 1);
            busy        <= 1'b1;
            state       <= BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_win1   <= pick1;
`endif
          end
        end
        BUSY: begin
          if (lat_cnt == '0) begin
            // Final edge: sample read data and release the bus together
            if (!we_q) begin
              if (grant[1]) rdata1 <= data_bus;
              else          rdata0 <= data_bus;
            end
            ack0        <= grant[0];
            ack1        <= grant[1];
            address_bus <= '0;
            write_mode  <= 1'b0;
            drive_en    <= 1'b0;
            state       <= DONE;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed transactions, a transaction-timeline
// reference model checked every cycle, plus literal expectations.
// While the arbiter should have released the data bus, the bench parks a
// value on it (zero, or memory read data), so any stray drive shows up as a
// corrupted bus value.
module tb_mem_bus_arbiter;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 16;
  localparam int READ_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ack0, ack1, busy, write_mode;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] address_bus;
  wire  [DATA_W-1:0] data_bus;

  logic              tb_oe;
  logic [DATA_W-1:0] tb_val;
  assign data_bus = tb_oe ? tb_val : {DATA_W{1'bz}};

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
    .busy(busy), .grant(grant), .address_bus(address_bus),
    .data_bus(data_bus), .write_mode(write_mode)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory device: written from the arbiter's pins
  logic [DATA_W-1:0] dev_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (write_mode) dev_mem[address_bus] <= data_bus;

  // Reference model: position within the current transaction timeline
  // (0 = idle, 1..len = address phase, len+1 = ack cycle)
  bit                m_valid = 1'b0;
  int                m_pos, m_len, m_port, m_ptr, m_w;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rd [2];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_pos   <= 0;
      m_len   <= 1;
      m_port  <= 0;
      m_ptr   <= 1;
      m_rd[0] <= '0;
      m_rd[1] <= '0;
    end else if (m_pos == 0) begin
      if (req0 || req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_w = (req0 && req1) ? (1 - m_ptr) : (req1 ? 1 : 0);
`else
        m_w = req0 ? 0 : 1;
`endif
        m_port  <= m_w;
        m_ptr   <= m_w;
        m_we    <= (m_w == 1) ? we1 : we0;
        m_addr  <= (m_w == 1) ? addr1 : addr0;
        m_wdata <= (m_w == 1) ? wdata1 : wdata0;
        m_len   <= (((m_w == 1) ? we1 : we0) == 1'b1) ? 1 : READ_LAT;
        m_pos   <= 1;
      end
    end else if (m_pos <= m_len) begin
      if (m_pos == m_len) begin
        if (m_we) shadow[m_addr] <= m_wdata;
        else      m_rd[m_port]   <= shadow[m_addr];
      end
      m_pos <= m_pos + 1;
    end else begin
      m_pos <= 0;
    end
  end

  logic in_win;
  always @* begin
    in_win = (m_pos >= 1) && (m_pos <= m_len);
    tb_oe  = !(in_win && m_we);
    tb_val = (in_win && !m_we) ? dev_mem[address_bus] : '0;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, m_pos != 0);
      chk("grant", grant, (m_pos == 0) ? 2'b00 : ((m_port == 1) ? 2'b10 : 2'b01));
      chk("address_bus", address_bus, in_win ? m_addr : '0);
      chk("write_mode", write_mode, in_win && m_we);
      chk("ack0", ack0, (m_pos != 0) && (m_pos == m_len + 1) && (m_port == 0));
      chk("ack1", ack1, (m_pos != 0) && (m_pos == m_len + 1) && (m_port == 1));
      chk("data_bus", data_bus, tb_oe ? tb_val : m_wdata);
      chk("rdata0", rdata0, m_rd[0]);
      chk("rdata1", rdata1, m_rd[1]);
    end
  end

  // One transaction from a single port; reports ack latency, write_mode
  // cycle count, and address/data bus seen in cycle 1
  task automatic txn(input int port, input logic we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input bit drop, output int lat,
                     output int wm, output logic [ADDR_W-1:0] a1, output logic [DATA_W-1:0] db1);
    lat = -1; wm = 0; a1 = '0; db1 = '0;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else           begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        a1 = address_bus;
        db1 = data_bus;
        if (drop) begin if (port == 0) req0 = 1'b0; else req1 = 1'b0; end
      end
      if (write_mode) wm++;
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin lat = n; break; end
    end
    @(posedge clk); #1;
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  int                lat, wm, ack1_seen;
  logic [ADDR_W-1:0] a1;
  logic [DATA_W-1:0] db1;
  logic [1:0]        gseq [4];
  bit                got;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin dev_mem[i] = '0; shadow[i] = '0; end
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_rdata0", rdata0, 16'h0000);

    // Port 0 writes 0xBEEF to 0x032
    txn(0, 1'b1, 12'h032, 16'hBEEF, 1'b0, lat, wm, a1, db1);
    chk("wr_ack_cycle", lat, 2);
    chk("wr_strobe_cycles", wm, 1);
    chk("wr_data_bus", db1, 16'hBEEF);
    chk("wr_rdata0_unchanged", rdata0, 16'h0000);

    // Port 1 reads it back
    txn(1, 1'b0, 12'h032, 16'h0000, 1'b0, lat, wm, a1, db1);
    chk("rd_ack_cycle", lat, READ_LAT + 1);
    chk("rd_addr", a1, 12'h032);
    chk("rd_no_strobe", wm, 0);
    chk("rd_rdata1", rdata1, 16'hBEEF);

    // Both ports requesting continuously for four transactions
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h100; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h101; wdata1 = 16'h2222;
    ack1_seen = 0;
    for (int k = 0; k < 4; k++) begin
      gseq[k] = 2'b00;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(posedge clk); #1;
        if (ack1) ack1_seen++;
        if (ack0 || ack1) begin gseq[k] = grant; got = 1'b1; end
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_grant0", gseq[0], 2'b01);
    chk("tie_grant1", gseq[1], 2'b10);
    chk("tie_grant2", gseq[2], 2'b01);
    chk("tie_grant3", gseq[3], 2'b10);
    chk("tie_ack1_count", ack1_seen, 2);
`else
    chk("tie_grant0", gseq[0], 2'b01);
    chk("tie_grant1", gseq[1], 2'b01);
    chk("tie_grant2", gseq[2], 2'b01);
    chk("tie_grant3", gseq[3], 2'b01);
    chk("tie_ack1_count", ack1_seen, 0);
`endif

    // Top address, no wrap
    txn(0, 1'b1, 12'hFFF, 16'h1234, 1'b0, lat, wm, a1, db1);
    chk("top_wr_addr", a1, 12'hFFF);
    txn(0, 1'b0, 12'hFFF, 16'h0000, 1'b0, lat, wm, a1, db1);
    chk("top_rd_addr", a1, 12'hFFF);
    chk("top_rd_rdata0", rdata0, 16'h1234);

    // Reset during the BUSY cycle of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h555; wdata0 = 16'hAAAA;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_write_mode", write_mode, 1'b0);
    chk("abort_address", address_bus, 12'h000);
    chk("abort_ack0", ack0, 1'b0);
    chk("abort_data_bus", data_bus, 16'h0000);
    @(posedge clk); #1;
    chk("abort_no_late_ack", ack0, 1'b0);
    txn(0, 1'b1, 12'h040, 16'h0777, 1'b0, lat, wm, a1, db1);
    chk("after_abort_wr_ack", lat, 2);
    txn(1, 1'b0, 12'h040, 16'h0000, 1'b0, lat, wm, a1, db1);
    chk("after_abort_rd_rdata1", rdata1, 16'h0777);

    // Request dropped in cycle 1 of a read
    txn(0, 1'b0, 12'h032, 16'h0000, 1'b1, lat, wm, a1, db1);
    chk("drop_ack_cycle", lat, READ_LAT + 1);
    chk("drop_rdata0", rdata0, 16'hBEEF);
    chk("drop_grant_idle", grant, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
